// File: rtl/can_mac_tx_serializer_pkg.sv
// Shared CAN MAC types: TX serializer and RX deserializer state enums, stuffing defaults.
// The TX bit monitor is enabled by defining CAN_TX_BIT_MONITOR_EN.
package can_mac_tx_serializer_pkg;

  localparam int unsigned STUFF_LEN_DEFAULT = 5;
  localparam int unsigned RUN_W             = 3;

  typedef logic [RUN_W-1:0] run_cnt_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    STUFF = 2'd2
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE    = 2'd0,
    RX_DATA    = 2'd1,
    RX_DESTUFF = 2'd2
  } rx_state_e;

  // Next run length: restart at 1 on a level change, saturate at lim otherwise.
  function automatic run_cnt_t run_next(input run_cnt_t run, input logic same,
                                        input run_cnt_t lim);
    if (!same)       return run_cnt_t'(1);
    else if (run >= lim) return lim;
    else             return run + run_cnt_t'(1);
  endfunction

endpackage

// File: rtl/can_mac_tx_serializer.sv
// CAN TX bit serializer with bit stuffing; one bit per can_clk_en strobe.
// Optional transmit bit monitor (rx_bit / bit_error) under CAN_TX_BIT_MONITOR_EN.
module can_mac_tx_serializer
  import can_mac_tx_serializer_pkg::*;
#(
  parameter int unsigned STUFF_LEN = STUFF_LEN_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic can_clk_en,
  input  logic bit_in,
  input  logic valid,
  output logic ready,
  input  logic stuffing_enable,
  output logic tx_bit,
  output logic stuff_bit,
  output logic busy
`ifdef CAN_TX_BIT_MONITOR_EN
  ,
  input  logic rx_bit,
  output logic bit_error
`endif
);

  localparam run_cnt_t STUFF_RUN = run_cnt_t'(STUFF_LEN);

  tx_state_e state_q, state_d;
  logic      tx_q, tx_d;
  logic      stuff_q, stuff_d;
  logic      last_q, last_d;
  logic      pend_q, pend_d;
  run_cnt_t  run_q, run_d;
  logic      accept;

  assign ready     = !pend_q;
  assign accept    = valid && ready && can_clk_en;
  assign tx_bit    = tx_q;
  assign stuff_bit = stuff_q;
  assign busy      = (state_q == SEND) || (state_q == STUFF);

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    stuff_d = stuff_q;
    last_d  = last_q;
    pend_d  = pend_q;
    run_d   = run_q;
    if (can_clk_en) begin
      if (pend_q) begin
        // Stuff bit opens a new run of the opposite level.
        state_d = STUFF;
        tx_d    = ~last_q;
        stuff_d = 1'b1;
        last_d  = ~last_q;
        run_d   = run_cnt_t'(1);
        pend_d  = 1'b0;
      end else if (accept) begin
        state_d = SEND;
        tx_d    = bit_in;
        stuff_d = 1'b0;
        last_d  = bit_in;
        run_d   = run_next(run_q, bit_in == last_q, STUFF_RUN);
        pend_d  = stuffing_enable && (run_d == STUFF_RUN);
      end else begin
        state_d = IDLE;
        tx_d    = 1'b1;
        stuff_d = 1'b0;
        last_d  = 1'b1;
        run_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      stuff_q <= 1'b0;
      last_q  <= 1'b1;
      pend_q  <= 1'b0;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      stuff_q <= stuff_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      run_q   <= run_d;
    end
  end

`ifdef CAN_TX_BIT_MONITOR_EN
  logic bit_err_q;

  assign bit_error = bit_err_q;

  // A recessive bit overwritten outside the stuffed region is arbitration/ACK, not an error.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_err_q <= 1'b0;
    end else if (can_clk_en) begin
      bit_err_q <= busy && (rx_bit != tx_q) && !(tx_q && !stuffing_enable);
    end
  end
`endif

endmodule

// File: tb/tb_can_mac_tx_serializer.sv
// Scoreboard bench for can_mac_tx_serializer: expected wire bits queued per frame, monitor pops per strobe.
module tb_can_mac_tx_serializer;

  localparam int L = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic can_clk_en = 1'b0;
  logic bit_in = 1'b1;
  logic valid = 1'b0;
  logic stuffing_enable = 1'b0;
  logic ready, tx_bit, stuff_bit, busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  typedef struct packed {logic tx; logic stf;} wire_t;
  wire_t exp_q[$];
  wire_t e;

`ifdef CAN_TX_BIT_MONITOR_EN
  logic rx_ovr = 1'b0;
  logic rx_val = 1'b1;
  logic rx_bit, bit_error;
  assign rx_bit = rx_ovr ? rx_val : tx_bit;
`endif

  can_mac_tx_serializer #(.STUFF_LEN(L)) dut (
    .clk(clk), .reset(reset), .can_clk_en(can_clk_en), .bit_in(bit_in),
    .valid(valid), .ready(ready), .stuffing_enable(stuffing_enable),
    .tx_bit(tx_bit), .stuff_bit(stuff_bit), .busy(busy)
`ifdef CAN_TX_BIT_MONITOR_EN
    , .rx_bit(rx_bit), .bit_error(bit_error)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every strobe while busy must match the head of the expected wire queue.
  always @(posedge clk) begin
    if (mon_en && can_clk_en && !reset) begin
      #1;
      if (busy) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_underflow: busy with empty queue, tx_bit=%b", tx_bit);
        end else begin
          e = exp_q.pop_front();
          chk("sb_tx", tx_bit, e.tx);
          chk("sb_stuff", stuff_bit, e.stf);
          chk("sb_ready", ready, (exp_q.size() > 0 && exp_q[0].stf) ? 0 : 1);
        end
      end else begin
        chk("sb_idle_tx", tx_bit, 1);
        chk("sb_idle_stuff", stuff_bit, 0);
        chk("sb_idle_ready", ready, 1);
      end
    end
  end

  task automatic strobe(output bit acc);
    @(negedge clk);
    can_clk_en = 1'b1;
    acc = valid && ready;
    @(negedge clk);
    can_clk_en = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  // Bits are taken MSB-first from pat[len-1:0]; stuffing_enable is high for the first nse bits.
  task automatic send_frame(input logic [31:0] pat, input int len, input int nse);
    logic w[$];
    logic s[$];
    logic b;
    int   n;
    bit   acc;
    int   tries;
    for (int i = 0; i < len; i++) begin
      b = pat[len-1-i];
      w.push_back(b);
      s.push_back(1'b0);
      n = 0;
      for (int k = w.size() - 1; k >= 0 && w[k] == b; k--) n++;
      if (i < nse && n == L) begin
        w.push_back(!b);
        s.push_back(1'b1);
      end
    end
    for (int k = 0; k < w.size(); k++) exp_q.push_back(wire_t'{w[k], s[k]});
    valid = 1'b1;
    for (int i = 0; i < len; i++) begin
      bit_in = pat[len-1-i];
      stuffing_enable = (i < nse);
      tries = 0;
      do begin
        strobe(acc);
        tries++;
      end while (!acc && tries < 4);
      if (!acc) chk("accept_timeout", 0, 1);
    end
    valid = 1'b0;
    stuffing_enable = 1'b0;
    strobe(acc);
    strobe(acc);
    chk("frame_drained", exp_q.size(), 0);
    chk("frame_idle_busy", busy, 0);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    logic [31:0] pat;
    logic prev;
    int len;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_tx", tx_bit, 1);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_stuff", stuff_bit, 0);

    mon_en = 1'b1;
    repeat (10) strobe(acc);

    send_frame(32'b111110, 6, 6);
    send_frame(32'b00000000, 8, 8);
    send_frame(32'b111111111111, 12, 5);
    send_frame(32'b111, 3, 3);
    send_frame(32'b111, 3, 3);
    send_frame(32'b0000011111000001, 16, 16);

    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 24);
      prev = 1'($urandom_range(0, 1));
      pat = '0;
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) prev = !prev;
        pat[i] = prev;
      end
      send_frame(pat, len, $urandom_range(0, len));
    end

    // Reset while a stuff bit is on the wire, with the strobe low.
    mon_en = 1'b0;
    valid = 1'b1;
    stuffing_enable = 1'b1;
    bit_in = 1'b1;
    repeat (L) strobe(acc);
    chk("pend_ready_low", ready, 0);
    @(negedge clk);
    can_clk_en = 1'b1;
    @(posedge clk);
    #1;
    chk("stuff_on_wire", stuff_bit, 1);
    chk("stuff_tx", tx_bit, 0);
    @(negedge clk);
    can_clk_en = 1'b0;
    reset = 1'b1;
    valid = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_tx", tx_bit, 1);
    chk("abort_ready", ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_stuff", stuff_bit, 0);
    @(negedge clk);
    reset = 1'b0;

`ifdef CAN_TX_BIT_MONITOR_EN
    valid = 1'b1;
    stuffing_enable = 1'b1;
    bit_in = 1'b1;
    strobe(acc);
    rx_ovr = 1'b1;
    rx_val = 1'b0;
    strobe(acc);
    chk("bit_err_set", bit_error, 1);
    rx_ovr = 1'b0;
    strobe(acc);
    chk("bit_err_clear", bit_error, 0);
    stuffing_enable = 1'b0;
    rx_ovr = 1'b1;
    rx_val = 1'b0;
    strobe(acc);
    chk("bit_err_arb", bit_error, 0);
    rx_ovr = 1'b0;
    valid = 1'b0;
    strobe(acc);
    strobe(acc);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
